vector_dot_product_param: RTL and testbench
===========================================

# vector_dot_product_param

Parametrised, fully pipelined multi-beat dot-product engine; successor to the fixed 8-lane, 8-bit tree-add unit. Each accepted beat multiplies `LANES` data/weight pairs, reduces them through a registered adder tree and accumulates across beats until `in_last`, then presents one result per packet. Signed/unsigned mode, wrap detection and full output backpressure are new. Sits between the activation stream source and the result writeback stage.

## Interface
- `LANES`, 8, number of multiply lanes; power of two, >= 2
- `DW`, 8, width of each data/weight element
- `ACCW`, 32, accumulator/result width; must be >= 2*DW + log2(LANES)
- `SIGNED`, 1, 1 = two's-complement operands and result, 0 = unsigned
- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — beat present
- `in_last` in 1 — beat is final of packet; qualified by `in_valid`
- `in_ready` out 1 — beat accepted on edge where `in_valid && in_ready`
- `t_data` in `[LANES-1:0][DW-1:0]` — data elements
- `weights` in `[LANES-1:0][DW-1:0]` — weight elements
- `out_valid` out 1 — result held
- `out_ready` in 1 — result consumed on edge where `out_valid && out_ready`
- `dot_product` out ACCW — packet sum, modulo 2^ACCW
- `out_overflow` out 1 — packet sum wrapped; valid with `out_valid`

## Operation
- Pipeline: stage M (LANES products, 2*DW bits, registered), T = log2(LANES) tree levels (each adds 1 bit, registered), stage A (accumulate + output register). Each stage carries a valid bit and a last bit.
- Operand extension: sign-extend when SIGNED=1, zero-extend when 0; tree result extended to ACCW before accumulation.
- Global stall: `stall = out_valid && !out_ready`. When stalled, every pipeline register, valid bit, accumulator and output register holds. `in_ready = !stall` (combinational).
- Stage A, valid non-last beat: `acc <= acc + tree_sum`; `ovf <= ovf | wrap`.
- Stage A, valid last beat: `dot_product <= acc + tree_sum`, `out_overflow <= ovf | wrap`, `out_valid <= 1`, `acc <= 0`, `ovf <= 0`. Single-beat packets allowed.
- Wrap: SIGNED=1 — operand signs equal and sum sign differs; SIGNED=0 — carry out of bit ACCW-1.
- Bubble (valid bit 0) reaching stage A: no effect on acc/ovf.
- Result consumed with no new last beat at stage A: `out_valid <= 0`, `dot_product` and `out_overflow` hold old value. Consume and new result on the same edge: load new, `out_valid` stays 1.
- `in_last` with `in_valid=0` ignored. Back-to-back packets need no gap.

## Timing
- Reset (async, any time, including mid-packet): all valid bits 0, acc 0, ovf 0, `out_valid` 0, `dot_product` 0, `out_overflow` 0; `in_ready` 1 while in reset and after release. Partial packets discarded.
- Latency: last beat accepted at edge k → `out_valid` high after edge k+T+2 (LANES=8: 5 cycles), absent stalls. Each stall cycle adds one.
- Throughput: one beat per cycle, one result per cycle sustained when `out_ready`=1.
- No combinational path from `in_valid`/data to any output; `in_ready` depends only on `out_valid` and `out_ready`.

## Test plan
- Defaults; one beat all lanes t=1,w=1, `in_last`=1, `out_ready`=1 → `out_valid` 5 cycles later, `dot_product`=8, `out_overflow`=0, single-cycle pulse.
- SIGNED=1; one beat t=0xFF (-1), w=0x7F in all lanes → `dot_product`=0xFFFFFC08 (-1016), overflow 0.
- Three-beat packet t=lane index, w=2, with idle cycles between beats → single result 3*56=168; no `out_valid` before last beat drains.
- Two back-to-back 1-beat packets (sums 8 and 16), `out_ready`=0 for 4 cycles → `in_ready`=0 while `out_valid`, first result 8 held stable, then 16 next cycle after release; no loss or duplication.
- SIGNED=0, ACCW=20; three beats all 0xFF → `dot_product`=512024 (1560600 mod 2^20), `out_overflow`=1; next packet (sum 8) reports overflow 0.
- Assert `rst_n`=0 after two beats of a packet (pipeline in flight) → all outputs 0 immediately; after release a fresh 1-beat packet yields exact sum with no residue.

Source files
------------

// File: rtl/vector_dot_product_param.sv
// Pipelined multi-beat dot product: operand regs, per-lane multiply, registered
// binary adder tree, then a packet accumulator with wrap tracking and output hold.
module dp_lane #(
  parameter int DW     = 8,
  parameter int PW     = 19,
  parameter int SIGNED = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [PW-1:0] p
);
  logic [DW-1:0]   a_q, b_q;
  logic [2*DW-1:0] prod;
  logic            ext;

  if (SIGNED != 0) begin : g_s
    assign prod = $signed({{DW{a_q[DW-1]}}, a_q}) * $signed({{DW{b_q[DW-1]}}, b_q});
    assign ext  = prod[2*DW-1];
  end else begin : g_u
    assign prod = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    assign ext  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      p   <= '0;
    end else if (en) begin
      a_q <= a;
      b_q <= b;
      p   <= {{(PW-2*DW){ext}}, prod};
    end
  end
endmodule

module vector_dot_product_param #(
  parameter int LANES  = 8,
  parameter int DW     = 8,
  parameter int ACCW   = 32,
  parameter int SIGNED = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [LANES-1:0][DW-1:0]   t_data,
  input  logic [LANES-1:0][DW-1:0]   weights,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACCW-1:0]            dot_product,
  output logic                       out_overflow
);
  localparam int T  = $clog2(LANES);
  localparam int PW = 2*DW + T;

  logic stall, en;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  // [0] operand regs, [1] products, [T+1] tree root
  logic [T+1:0] vld_pipe, lst_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[T:0], in_valid};
      lst_pipe <= {lst_pipe[T:0], in_valid & in_last};
    end
  end

  logic [LANES-1:0][PW-1:0] prod;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dp_lane #(.DW(DW), .PW(PW), .SIGNED(SIGNED)) u_lane (
      .clk(clk), .rst_n(rst_n), .en(en),
      .a(t_data[g]), .b(weights[g]), .p(prod[g])
    );
  end

  // Heap-ordered tree: node i sums children 2i and 2i+1; leaves sit at LANES..2*LANES-1
  logic [LANES-1:1][PW-1:0]   node;
  logic [2*LANES-1:1][PW-1:0] tr;

  always_comb begin
    tr = '0;
    for (int i = 1; i < LANES; i++) tr[i] = node[i];
    for (int i = 0; i < LANES; i++) tr[LANES+i] = prod[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) node <= '0;
    else if (en)
      for (int i = 1; i < LANES; i++) node[i] <= tr[2*i] + tr[2*i+1];
  end

  logic [ACCW-1:0] acc, root_x, sum;
  logic [ACCW:0]   sum_w;
  logic            ovf, wrap;

  if (SIGNED != 0) begin : g_rs
    assign root_x = ACCW'($signed(node[1]));
  end else begin : g_ru
    assign root_x = ACCW'(node[1]);
  end

  assign sum_w = {1'b0, acc} + {1'b0, root_x};
  assign sum   = sum_w[ACCW-1:0];
  assign wrap  = (SIGNED != 0) ? ((acc[ACCW-1] == root_x[ACCW-1]) && (sum[ACCW-1] != acc[ACCW-1]))
                               : sum_w[ACCW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      dot_product  <= '0;
      out_overflow <= 1'b0;
    end else if (en) begin
      out_valid <= vld_pipe[T+1] & lst_pipe[T+1];
      if (vld_pipe[T+1]) begin
        if (lst_pipe[T+1]) begin
          dot_product  <= sum;
          out_overflow <= ovf | wrap;
          acc          <= '0;
          ovf          <= 1'b0;
        end else begin
          acc <= sum;
          ovf <= ovf | wrap;
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_dot_product_param.sv
// Drives a signed/32-bit and an unsigned/20-bit instance with identical beats and
// checks both against packet sums computed with plain integer arithmetic.
module tb_vector_dot_product_param;
  logic            clk, rst_n, in_valid, in_last, out_ready;
  logic [7:0][7:0] t_data, weights;
  logic            in_ready0, out_valid0, ovf0;
  logic            in_ready1, out_valid1, ovf1;
  logic [31:0]     dot0;
  logic [19:0]     dot1;

  vector_dot_product_param u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready0),
    .t_data(t_data), .weights(weights), .out_valid(out_valid0), .out_ready(out_ready),
    .dot_product(dot0), .out_overflow(ovf0)
  );
  vector_dot_product_param #(.SIGNED(0), .ACCW(20)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready1),
    .t_data(t_data), .weights(weights), .out_valid(out_valid1), .out_ready(out_ready),
    .dot_product(dot1), .out_overflow(ovf1)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit rnd_on;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { longint v; bit o; } exp_t;
  exp_t   q0[$], q1[$];
  longint acc_m[2];
  bit     ovf_m[2];

  function automatic longint beat_sum(input bit sg);
    longint s = 0;
    for (int i = 0; i < 8; i++) begin
      if (sg) s += longint'($signed(t_data[i])) * longint'($signed(weights[i]));
      else    s += longint'(t_data[i]) * longint'(weights[i]);
    end
    return s;
  endfunction

  // Exact running sum kept modulo 2^W; a wrap is any step leaving the representable range
  function automatic void mdl(input int d, input bit last);
    int     w  = d ? 20 : 32;
    bit     sg = (d == 0);
    longint md = longint'(1) << w;
    longint s  = acc_m[d] + beat_sum(sg);
    bit     wr = sg ? (s < -(md/2) || s >= md/2) : (s >= md);
    longint m  = ((s % md) + md) % md;
    exp_t   e;
    if (last) begin
      e.v = m; e.o = ovf_m[d] | wr;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      acc_m[d] = 0; ovf_m[d] = 0;
    end else begin
      acc_m[d] = (sg && m >= md/2) ? m - md : m;
      ovf_m[d] = ovf_m[d] | wr;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid0", out_valid0, 0); chk("rst_dot0", dot0, 0); chk("rst_ovf0", ovf0, 0);
      chk("rst_ready0", in_ready0, 1);
      chk("rst_valid1", out_valid1, 0); chk("rst_dot1", dot1, 0); chk("rst_ovf1", ovf1, 0);
      chk("rst_ready1", in_ready1, 1);
      q0.delete(); q1.delete();
      acc_m[0] = 0; acc_m[1] = 0; ovf_m[0] = 0; ovf_m[1] = 0;
    end else begin
      chk("in_ready0", in_ready0, !(out_valid0 && !out_ready));
      chk("in_ready1", in_ready1, !(out_valid1 && !out_ready));
      if (out_valid0) begin
        chk("valid0_expected", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          chk("dot0", dot0, q0[0].v); chk("ovf0", ovf0, q0[0].o);
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (out_valid1) begin
        chk("valid1_expected", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          chk("dot1", dot1, q1[0].v); chk("ovf1", ovf1, q1[0].o);
          if (out_ready) void'(q1.pop_front());
        end
      end
      if (in_valid && in_ready0) begin
        mdl(0, in_last);
        mdl(1, in_last);
      end
    end
  end

  function automatic logic [7:0][7:0] fill(input logic [7:0] v);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [7:0][7:0] t, input logic [7:0][7:0] w, input bit last);
    int n = 0;
    bit ok;
    t_data = t; weights = w; in_last = last; in_valid = 1;
    do begin
      @(negedge clk); ok = in_ready0;
      step(); n++;
    end while (!ok && n < 200);
    chk("send_accepted", ok, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic idle(input int n, input bit no_out);
    repeat (n) begin
      @(negedge clk);
      if (no_out) chk("no_early_valid", out_valid0, 0);
      step();
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!out_valid0 && n < 50);
    chk("wait_out_valid", out_valid0, 1);
  endtask

  logic [7:0][7:0] tv, wv;
  int n;

  initial begin
    clk = 0; rst_n = 0; in_valid = 0; in_last = 0; out_ready = 1;
    t_data = '0; weights = '0; rnd_on = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    step();

    // single beat of ones: latency and one-cycle pulse
    send(fill(8'd1), fill(8'd1), 1);
    wait_out(n);
    chk("t1_latency", n, 5); chk("t1_dot0", dot0, 8); chk("t1_ovf0", ovf0, 0); chk("t1_dot1", dot1, 8);
    @(negedge clk); chk("t1_pulse", out_valid0, 0);
    step();

    send(fill(8'hFF), fill(8'h7F), 1);
    wait_out(n);
    chk("t2_dot0", dot0, 32'hFFFFFC08); chk("t2_ovf0", ovf0, 0);
    chk("t2_dot1", dot1, 259080); chk("t2_ovf1", ovf1, 0);
    step();

    // three beats with gaps; nothing may emerge before the last one drains
    for (int i = 0; i < 8; i++) tv[i] = 8'(i);
    send(tv, fill(8'd2), 0); idle(2, 1);
    send(tv, fill(8'd2), 0); idle(2, 1);
    send(tv, fill(8'd2), 1);
    wait_out(n);
    chk("t3_latency", n, 5); chk("t3_dot0", dot0, 168); chk("t3_dot1", dot1, 168);
    step();

    // back-to-back packets held under backpressure
    out_ready = 0;
    send(fill(8'd1), fill(8'd1), 1);
    send(fill(8'd2), fill(8'd1), 1);
    wait_out(n);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      chk("t4_hold_ready", in_ready0, 0); chk("t4_hold_valid", out_valid0, 1);
      chk("t4_hold_dot", dot0, 8);
    end
    step(); out_ready = 1;
    @(negedge clk); chk("t4_rel_valid", out_valid0, 1); chk("t4_rel_dot", dot0, 8);
    @(negedge clk); chk("t4_next_valid", out_valid0, 1); chk("t4_next_dot0", dot0, 16);
    chk("t4_next_dot1", dot1, 16);
    @(negedge clk); chk("t4_done", out_valid0, 0);
    step();

    // unsigned 20-bit wrap, then a clean packet
    send(fill(8'hFF), fill(8'hFF), 0);
    send(fill(8'hFF), fill(8'hFF), 0);
    send(fill(8'hFF), fill(8'hFF), 1);
    wait_out(n);
    chk("t5_dot1", dot1, 512024); chk("t5_ovf1", ovf1, 1);
    chk("t5_dot0", dot0, 24); chk("t5_ovf0", ovf0, 0);
    step();
    send(fill(8'd1), fill(8'd1), 1);
    wait_out(n);
    chk("t5b_dot1", dot1, 8); chk("t5b_ovf1", ovf1, 0);
    step();

    // reset while a result is held, then reset with a partial packet in flight
    out_ready = 0;
    send(fill(8'd1), fill(8'd1), 1);
    wait_out(n);
    #2 rst_n = 0;
    #1 chk("t6_valid", out_valid0, 0); chk("t6_dot", dot0, 0); chk("t6_ready", in_ready0, 1);
    step(); step(); rst_n = 1; out_ready = 1;
    step();
    send(fill(8'h55), fill(8'h33), 0);
    send(fill(8'h77), fill(8'h22), 0);
    #2 rst_n = 0;
    #1 chk("t6b_valid", out_valid0, 0); chk("t6b_dot", dot0, 0);
    step(); step(); rst_n = 1;
    step();
    send(fill(8'd3), fill(8'd1), 1);
    wait_out(n);
    chk("t6c_dot0", dot0, 24); chk("t6c_ovf0", ovf0, 0); chk("t6c_dot1", dot1, 24);
    step();

    // randomized packets with random backpressure and gaps
    rnd_on = 1;
    for (int p = 0; p < 150; p++) begin
      int len = $urandom_range(1, 4);
      bit hi  = ($urandom_range(0, 1) == 1);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < 8; i++) begin
          tv[i] = hi ? 8'($urandom_range(200, 255)) : 8'($urandom);
          wv[i] = hi ? 8'($urandom_range(200, 255)) : 8'($urandom);
        end
        send(tv, wv, b == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 0);
      end
    end
    rnd_on = 0; out_ready = 1;
    idle(20, 0);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
